// File: rtl/alu_arbiter_if.sv
// Per-port request/response channel between one ALU requester and the arbiter.
// The requester drives the master side and the arbiter drives the slave side.
interface alu_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_ctrl;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_ctrl, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_ctrl, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared integer ALU: one registered execute
// stage feeds the external ALU, and each port owns a single response register.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_arbiter_if.slave     p0,
    alu_arbiter_if.slave     p1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             alu_v,
    input  logic             alu_c,
    output logic             busy
);

    logic             x_v;
    logic             x_port;
    logic             last_grant;
    logic             rsp0_v, rsp1_v;
    logic [WIDTH-1:0] rsp0_res, rsp1_res;
    logic [3:0]       rsp0_fl, rsp1_fl;

    logic             x_drain;
    logic             can_acc;
    logic             gnt_vld;
    logic             gnt_port;
    logic             accept;
    logic             drain0, drain1;

    // The stage empties when its target response register is free or being consumed.
    assign x_drain = x_v & (x_port ? (~rsp1_v | p1.rsp_ready)
                                   : (~rsp0_v | p0.rsp_ready));
    assign can_acc = ~x_v | x_drain;
    assign drain0  = x_drain & ~x_port;
    assign drain1  = x_drain &  x_port;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_port = 1'b0;
        if (can_acc) begin
            if (p0.req_valid && p1.req_valid) begin
                gnt_vld  = 1'b1;
                gnt_port = RR_EN ? ~last_grant : 1'b0;
            end else if (p0.req_valid) begin
                gnt_vld  = 1'b1;
            end else if (p1.req_valid) begin
                gnt_vld  = 1'b1;
                gnt_port = 1'b1;
            end
        end
    end

    assign accept       = gnt_vld;
    assign p0.req_ready = gnt_vld & ~gnt_port;
    assign p1.req_ready = gnt_vld &  gnt_port;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_v        <= 1'b0;
            x_port     <= 1'b0;
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= 3'b000;
        end else if (accept) begin
            x_v        <= 1'b1;
            x_port     <= gnt_port;
            last_grant <= gnt_port;
            alu_a      <= gnt_port ? p1.req_a    : p0.req_a;
            alu_b      <= gnt_port ? p1.req_b    : p0.req_b;
            alu_ctrl   <= gnt_port ? p1.req_ctrl : p0.req_ctrl;
        end else if (x_drain) begin
            // Operands are left as-is; only the occupancy bit clears.
            x_v <= 1'b0;
        end
    end

    // A refill in the same cycle as a consume wins, keeping the register valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_v   <= 1'b0;
            rsp0_res <= '0;
            rsp0_fl  <= 4'b0000;
        end else if (drain0) begin
            rsp0_v   <= 1'b1;
            rsp0_res <= alu_result;
            rsp0_fl  <= {alu_z, alu_n, alu_v, alu_c};
        end else if (p0.rsp_ready) begin
            rsp0_v   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_v   <= 1'b0;
            rsp1_res <= '0;
            rsp1_fl  <= 4'b0000;
        end else if (drain1) begin
            rsp1_v   <= 1'b1;
            rsp1_res <= alu_result;
            rsp1_fl  <= {alu_z, alu_n, alu_v, alu_c};
        end else if (p1.rsp_ready) begin
            rsp1_v   <= 1'b0;
        end
    end

    assign p0.rsp_valid  = rsp0_v;
    assign p0.rsp_result = rsp0_res;
    assign p0.rsp_flags  = rsp0_fl;
    assign p1.rsp_valid  = rsp1_v;
    assign p1.rsp_result = rsp1_res;
    assign p1.rsp_flags  = rsp1_fl;

    assign busy = x_v | rsp0_v | rsp1_v;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin and a fixed-priority instance,
// each with a behavioural ALU, and a response scoreboard fed by the stimulus.
module tb_alu_arbiter;
    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       ctrl;
        logic [WIDTH+3:0] exp;
    } op_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WIDTH(WIDTH)) a0 ();
    alu_arbiter_if #(.WIDTH(WIDTH)) a1 ();
    alu_arbiter_if #(.WIDTH(WIDTH)) f0 ();
    alu_arbiter_if #(.WIDTH(WIDTH)) f1 ();

    logic [WIDTH-1:0] ra_a, ra_b, ra_res, fa_a, fa_b, fa_res;
    logic [2:0]       ra_ctrl, fa_ctrl;
    logic [3:0]       ra_fl, fa_fl;
    logic             ra_busy, fa_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH+3:0] exp0[$];
    logic [WIDTH+3:0] exp1[$];

    // Reference ALU: returns {result, Z, N, V, C}; C is the raw carry out of a + ~b + 1 for sub.
    function automatic logic [WIDTH+3:0] alu_model(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [2:0]       ctrl);
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] r;
        logic             v, c;
        s = '0;
        r = '0;
        v = 1'b0;
        c = 1'b0;
        case (ctrl)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[WIDTH-1:0];
                c = s[WIDTH];
                v = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
                r = s[WIDTH-1:0];
                c = s[WIDTH];
                v = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b101:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: r = '0;
        endcase
        return {r, (r == '0), r[WIDTH-1], v, c};
    endfunction

    assign {ra_res, ra_fl} = alu_model(ra_a, ra_b, ra_ctrl);
    assign {fa_res, fa_fl} = alu_model(fa_a, fa_b, fa_ctrl);

    alu_arbiter #(.WIDTH(WIDTH), .RR_EN(1'b1)) u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .p0         (a0),
        .p1         (a1),
        .alu_a      (ra_a),
        .alu_b      (ra_b),
        .alu_ctrl   (ra_ctrl),
        .alu_result (ra_res),
        .alu_z      (ra_fl[3]),
        .alu_n      (ra_fl[2]),
        .alu_v      (ra_fl[1]),
        .alu_c      (ra_fl[0]),
        .busy       (ra_busy)
    );

    alu_arbiter #(.WIDTH(WIDTH), .RR_EN(1'b0)) u_fp (
        .clk        (clk),
        .rst_n      (rst_n),
        .p0         (f0),
        .p1         (f1),
        .alu_a      (fa_a),
        .alu_b      (fa_b),
        .alu_ctrl   (fa_ctrl),
        .alu_result (fa_res),
        .alu_z      (fa_fl[3]),
        .alu_n      (fa_fl[2]),
        .alu_v      (fa_fl[1]),
        .alu_c      (fa_fl[0]),
        .busy       (fa_busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a0(input logic v, input op_t op);
        a0.req_valid = v;
        a0.req_a     = op.a;
        a0.req_b     = op.b;
        a0.req_ctrl  = op.ctrl;
    endtask

    task automatic drive_a1(input logic v, input op_t op);
        a1.req_valid = v;
        a1.req_a     = op.a;
        a1.req_b     = op.b;
        a1.req_ctrl  = op.ctrl;
    endtask

    // Scoreboard monitor: every consumed response must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (a0.rsp_valid && a0.rsp_ready) begin
                if (exp0.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp0_unexpected: got %h, expected none", {a0.rsp_result, a0.rsp_flags});
                end else begin
                    check("rsp0", {a0.rsp_result, a0.rsp_flags}, exp0.pop_front());
                end
            end
            if (a1.rsp_valid && a1.rsp_ready) begin
                if (exp1.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rsp1_unexpected: got %h, expected none", {a1.rsp_result, a1.rsp_flags});
                end else begin
                    check("rsp1", {a1.rsp_result, a1.rsp_flags}, exp1.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    op_t idle, op_add, op_sub, op_fp;
    op_t tie0[3], tie1[3], cr[4];
    op_t bp1, bp2, bp3, op_c4, ra, rb;

    initial begin
        idle   = '{32'd0, 32'd0, 3'b000, 36'h0};
        op_add = '{32'd5, 32'd7, 3'b000, {32'd12, 4'b0000}};
        op_sub = '{32'd3, 32'd5, 3'b001, {32'hFFFF_FFFE, 4'b0100}};
        op_fp  = '{32'd4, 32'd4, 3'b000, {32'd8, 4'b0000}};
        tie0[0] = '{32'd10, 32'd1, 3'b000, {32'd11, 4'b0000}};
        tie0[1] = '{32'hFFFF_FFFF, 32'd1, 3'b101, {32'd1, 4'b0000}};
        tie0[2] = '{32'd6, 32'd6, 3'b000, {32'd12, 4'b0000}};
        tie1[0] = '{32'd100, 32'd1, 3'b001, {32'd99, 4'b0001}};
        tie1[1] = '{32'hF0, 32'h3C, 3'b010, {32'h30, 4'b0000}};
        tie1[2] = '{32'd8, 32'd8, 3'b001, {32'd0, 4'b1001}};
        cr[0] = '{32'd1, 32'd2, 3'b000, {32'd3, 4'b0000}};
        cr[1] = '{32'h7FFF_FFFF, 32'd1, 3'b000, {32'h8000_0000, 4'b0110}};
        cr[2] = '{32'hFFFF_FFFF, 32'd1, 3'b000, {32'h0, 4'b1001}};
        cr[3] = '{32'd5, 32'hA, 3'b011, {32'hF, 4'b0000}};
        bp1   = '{32'd1, 32'd1, 3'b000, {32'd2, 4'b0000}};
        bp2   = '{32'd2, 32'd2, 3'b000, {32'd4, 4'b0000}};
        bp3   = '{32'd7, 32'd1, 3'b000, {32'd8, 4'b0000}};
        op_c4 = '{32'd1, 32'd2, 3'b100, {32'd0, 4'b1000}};
        ra    = '{32'd9, 32'd1, 3'b000, 36'h0};
        rb    = '{32'd10, 32'd1, 3'b000, 36'h0};

        rst_n = 1'b0;
        drive_a0(1'b0, idle);
        drive_a1(1'b0, idle);
        f0.req_valid = 1'b0; f0.req_a = op_fp.a; f0.req_b = op_fp.b; f0.req_ctrl = op_fp.ctrl;
        f1.req_valid = 1'b0; f1.req_a = op_fp.a; f1.req_b = op_fp.b; f1.req_ctrl = op_fp.ctrl;
        a0.rsp_ready = 1'b1;
        a1.rsp_ready = 1'b1;
        f0.rsp_ready = 1'b1;
        f1.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", ra_busy, 1'b0);
        check("rst_rsp0_valid", a0.rsp_valid, 1'b0);
        check("rst_rsp1_valid", a1.rsp_valid, 1'b0);
        check("rst_alu_a", ra_a, 32'd0);
        check("rst_alu_ctrl", ra_ctrl, 3'b000);
        check("rst_rsp0_result", {a0.rsp_result, a0.rsp_flags}, 36'h0);
        tick();
        rst_n = 1'b1;

        // Single add on port 0
        drive_a0(1'b1, op_add);
        @(negedge clk);
        check("add_req0_ready", a0.req_ready, 1'b1);
        check("add_req1_ready", a1.req_ready, 1'b0);
        exp0.push_back(op_add.exp);
        tick();
        drive_a0(1'b0, idle);
        @(negedge clk);
        check("add_alu_a", ra_a, 32'd5);
        check("add_alu_b", ra_b, 32'd7);
        check("add_rsp0_not_yet", a0.rsp_valid, 1'b0);
        tick();
        @(negedge clk);
        check("add_rsp0_valid", a0.rsp_valid, 1'b1);
        check("add_rsp1_idle", a1.rsp_valid, 1'b0);
        tick();

        // Subtract on port 1, negative result
        drive_a1(1'b1, op_sub);
        @(negedge clk);
        check("sub_req1_ready", a1.req_ready, 1'b1);
        exp1.push_back(op_sub.exp);
        tick();
        drive_a1(1'b0, idle);
        repeat (3) tick();

        // Ties from reset: round-robin 0,1,0,1 and fixed priority 0,0,0,0
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        begin
            int i0, i1;
            i0 = 0;
            i1 = 0;
            f0.req_valid = 1'b1;
            f1.req_valid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                drive_a0(1'b1, tie0[i0]);
                drive_a1(1'b1, tie1[i1]);
                @(negedge clk);
                check("tie_rr_ready0", a0.req_ready, (i % 2) == 0);
                check("tie_rr_ready1", a1.req_ready, (i % 2) == 1);
                check("tie_fp_ready0", f0.req_ready, 1'b1);
                check("tie_fp_ready1", f1.req_ready, 1'b0);
                if ((i % 2) == 0) begin
                    exp0.push_back(tie0[i0].exp);
                    i0++;
                end else begin
                    exp1.push_back(tie1[i1].exp);
                    i1++;
                end
                tick();
            end
        end
        drive_a0(1'b0, idle);
        drive_a1(1'b0, idle);
        f0.req_valid = 1'b0;
        f1.req_valid = 1'b0;
        repeat (3) tick();

        // Backpressure on port 0 with head-of-line blocking of port 1
        a0.rsp_ready = 1'b0;
        drive_a0(1'b1, bp1);
        @(negedge clk);
        check("bp_first_ready", a0.req_ready, 1'b1);
        exp0.push_back(bp1.exp);
        tick();
        drive_a0(1'b1, bp2);
        @(negedge clk);
        check("bp_second_ready", a0.req_ready, 1'b1);
        exp0.push_back(bp2.exp);
        tick();
        drive_a0(1'b0, idle);
        drive_a1(1'b1, bp3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_stall_req1_ready", a1.req_ready, 1'b0);
            check("bp_held_rsp0", {a0.rsp_valid, a0.rsp_result}, {1'b1, 32'd2});
            check("bp_busy", ra_busy, 1'b1);
            tick();
        end
        a0.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_req1_ready", a1.req_ready, 1'b1);
        exp1.push_back(bp3.exp);
        tick();
        drive_a1(1'b0, idle);
        repeat (3) tick();

        // Back-to-back port 0 ops: response register refilled while consumed
        for (int i = 0; i < 4; i++) begin
            drive_a0(1'b1, cr[i]);
            @(negedge clk);
            check("cr_req0_ready", a0.req_ready, 1'b1);
            if (i >= 2) check("cr_rsp0_valid", a0.rsp_valid, 1'b1);
            exp0.push_back(cr[i].exp);
            tick();
        end
        drive_a0(1'b0, idle);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("cr_rsp0_valid_tail", a0.rsp_valid, 1'b1);
            tick();
        end

        // Unlisted ctrl code reaches the ALU unchanged
        drive_a0(1'b1, op_c4);
        @(negedge clk);
        exp0.push_back(op_c4.exp);
        tick();
        drive_a0(1'b0, idle);
        @(negedge clk);
        check("ctrl100_alu_ctrl", ra_ctrl, 3'b100);
        repeat (3) tick();

        // Asynchronous reset with an op in flight and a held response
        a1.rsp_ready = 1'b0;
        drive_a1(1'b1, ra);
        tick();
        drive_a1(1'b1, rb);
        tick();
        drive_a1(1'b0, idle);
        @(negedge clk);
        check("rmo_busy_before", ra_busy, 1'b1);
        check("rmo_rsp1_before", a1.rsp_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rmo_rsp0_valid", a0.rsp_valid, 1'b0);
        check("rmo_rsp1_valid", a1.rsp_valid, 1'b0);
        check("rmo_alu_a", ra_a, 32'd0);
        check("rmo_busy", ra_busy, 1'b0);
        tick();
        rst_n = 1'b1;
        a1.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rmo_no_rsp1", a1.rsp_valid, 1'b0);
        end
        check("rmo_busy_after", ra_busy, 1'b0);

        check("sb_exp0_drained", exp0.size(), 0);
        check("sb_exp1_drained", exp1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single integer ALU between two requesters: port 0 is the execute stage and port 1 is the address/branch helper. The block arbitrates valid/ready requests, registers the granted operands into one execute stage that drives the ALU, and captures the result and flags into a per-port response register. It sits between the core control path and the combinational ALU, which is instantiated outside this block.

Parameters:
WIDTH, 32, operand and result width
RR_EN, 1, 1 = round-robin on ties; 0 = fixed priority, port 0 wins

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid, req1_valid  in  1  request valid per port
req0_ready, req1_ready  out  1  request accepted this cycle (combinational)
req0_a, req1_a, req0_b, req1_b  in  WIDTH  operands
req0_ctrl, req1_ctrl  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
rsp0_valid, rsp1_valid  out  1  response held valid
rsp0_ready, rsp1_ready  in  1  response consumed
rsp0_result, rsp1_result  out  WIDTH  captured ALU result
rsp0_flags, rsp1_flags  out  4  captured {Z,N,V,C}
alu_a, alu_b  out  WIDTH  ALU operands, registered
alu_ctrl  out  3  ALU control, registered
alu_result  in  WIDTH  ALU result, combinational from alu_a/alu_b/alu_ctrl
alu_z, alu_n, alu_v, alu_c  in  1  ALU flags
busy  out  1  execute stage or any response register occupied

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Values held in reset: rsp*_valid=0, rsp*_result=0, rsp*_flags=0, alu_a=0, alu_b=0, alu_ctrl=000, execute-stage valid x_v=0, last_grant=1 (so port 0 wins the first tie), busy=0.
- Execute stage registers: x_v, x_port, alu_a, alu_b, alu_ctrl.
- Drain condition: x_drain = x_v & (~rspP_valid | rspP_ready), where P = x_port.
- Accept condition: can_acc = ~x_v | x_drain.
- Grant, combinational:
  - Grant only when can_acc=1.
  - One requester valid: grant that requester.
  - Both valid: with RR_EN=1, grant the port != last_grant; with RR_EN=0, grant port 0.
  - reqN_ready = can_acc & grant==N. At most one ready per cycle.
- On accept at edge k:
  - alu_a/alu_b/alu_ctrl <= granted operands, x_port <= N, x_v <= 1.
  - last_grant <= N.
- If a drain occurs with no accept: x_v <= 0. alu_* hold their last value; they are not cleared.
- On drain at edge k+1: rspP_result <= alu_result, rspP_flags <= {alu_z,alu_n,alu_v,alu_c}, rspP_valid <= 1.
- Response register: rspP_valid clears on rspP_ready when no new drain targets port P in the same cycle. A simultaneous consume and refill keeps valid=1 and loads the new data.
- Latency: request accepted at edge k gives rsp valid after edge k+1. Throughput is 1 op/cycle while responses are consumed.
- Backpressure: when a port's response register is full and not being consumed, an op for that port stalls in the execute stage. No further accepts for either port occur until it drains (head-of-line blocking is intended).
- Ordering: per-port responses are delivered in request order.
- Requester rules:
  - Hold a/b/ctrl stable while valid & ~ready.
  - valid must not depend combinationally on ready.
- Ctrl codes 100/110/111 are forwarded unchanged. The result is whatever the ALU returns; no error is raised.
- Flags are captured verbatim from the ALU with no reinterpretation.
- Reset mid-operation: in-flight and held responses are discarded, and no response is emitted after reset release.
- busy = x_v | rsp0_valid | rsp1_valid.

Test Plan:
- Single add: port 0 req a=5, b=7, ctrl=000, rsp0_ready=1 -> req0_ready=1 same cycle; alu_a=5 next cycle; rsp0_valid=1 one cycle later with result=12; rsp1_valid stays 0.
- Sub flags: port 1 a=3, b=5, ctrl=001 -> rsp1_result=0xFFFFFFFE, flags N=1, V=0, C=0.
- Tie round-robin: both ports valid every cycle for 4 cycles, RR_EN=1, responses always ready -> grants 0,1,0,1 starting from reset. With RR_EN=0 -> grants 0,0,0,0 and req1_ready stays 0.
- Backpressure: rsp0_ready=0, port 0 issues two adds (1+1, 2+2) -> first held in rsp0 (2); second stalls in execute; port 1 request sees ready=0. Raise rsp0_ready -> rsp0 shows 2, then 4; port 1 is granted the cycle the stall clears.
- Simultaneous consume/refill: back-to-back port 0 ops with rsp0_ready=1 -> rsp0_valid stays high continuously and the result updates every cycle.
- Reset mid-op: assert rst_n=0 while x_v=1 and rsp1_valid=1 -> all valids 0 and alu_a=0 immediately (asynchronously); after release no response appears; busy=0.
